seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; next generation of the fixed 3-bit "111" detector.
- Pattern, length, overlap mode and detection-counter width are all set by parameters.
- Adds a qualifying valid strobe, a saturating detection counter and an exposed match-progress state.
- Sits on a 1-bit serial input stream, e.g. a deserialised line or a sync-word hunt, and flags each pattern occurrence with a registered pulse.

Parameters:
- LEN, 3, pattern length in bits; legal range 1..16.
- PATTERN, 3'b111, LEN-bit pattern. PATTERN[LEN-1] is the first bit expected on the line (MSB first).
- OVERLAP, 1:
  - 1 = overlapping detection; after a hit, progress resumes from the longest proper border of PATTERN.
  - 0 = non-overlapping; progress restarts at 0 after a hit.
- CNT_W, 8, width of the detection counter.
- SW (local, derived), $clog2(LEN)+1, width of the state port.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  reset, synchronous, active-high.
- in  input  1  serial data bit.
- in_valid  input  1  in is sampled only when 1.
- out  output  1  registered detection pulse, one cycle per hit.
- state  output  SW  match progress (0..LEN-1).
- count  output  CNT_W  saturating number of detections since clear.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, clear).
- Reset: clear=1 at a rising edge forces state=0, out=0, count=0. Reset takes priority over in_valid and any pending hit. A mid-pattern clear discards partial progress.
- state definition: the longest suffix of accepted bits that is a proper prefix of PATTERN, limited to LEN-1.
  - "Accepted bits" are those sampled since the last clear, or since the last hit when OVERLAP=0.
  - state never holds LEN.
- Update when in_valid=1, with s = current state, b = in:
  - If b equals expected bit PATTERN[LEN-1-s] and s+1 < LEN: state <= s+1, out <= 0.
  - If b matches and s+1 == LEN (hit):
    - out <= 1.
    - count <= count+1, unless count is all-ones, in which case it holds.
    - state <= B if OVERLAP=1, where B = longest proper border of PATTERN. Otherwise state <= 0.
  - Mismatch: state <= longest k < s+1 such that PATTERN prefix of length k equals the last k accepted bits (standard failure-function back-off; may be nonzero). out <= 0.
- When in_valid=0: state and count hold; out <= 0.
- Latency: out is high in the cycle after the rising edge that samples the completing bit. It is exactly one cycle wide per hit. Back-to-back hits give consecutive high cycles; for example, "111" with OVERLAP=1 on a run of ones.
- LEN=1: every accepted bit equal to PATTERN[0] is a hit; state is constantly 0.
- Border and failure values are computed at elaboration from PATTERN; no runtime pattern load.
- count saturates at 2^CNT_W-1 and never wraps; only clear returns it to 0.
- No X on outputs after the first clear edge.

Test Plan:
- LEN=3, PATTERN=111, OVERLAP=1, clear for 1 cycle, then in_valid=1 and in = 1,1,1,1,1,0,0 -> out high after bits 3, 4 and 5 (three consecutive cycles); state sequence 1,2,2,2,2,0,0; final count=3.
- Same stream with OVERLAP=0 -> single out pulse after bit 3; state sequence 1,2,0,1,2,0,0; count=1.
- LEN=4, PATTERN=1011, OVERLAP=1, in = 1,0,1,1,0,1,1 -> hits after bits 4 and 7; state after bit 4 = 1, after bit 5 = 2; count=2. With OVERLAP=0 -> only the hit after bit 4; state after bit 7 = 1; count=1.
- PATTERN=111, in = 1,1 then in_valid=0 for 3 cycles with in=0, then in_valid=1 with in=1 -> state holds 2 during the gap and out stays 0; hit after the final bit.
- PATTERN=111, in = 1,1 then clear=1 for one cycle while in=1 -> state=0, count=0, out=0 after that edge; then 3 more ones are needed for a hit.
- CNT_W=2, PATTERN=111, OVERLAP=1, seven consecutive ones -> 5 out pulses; count goes 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-sequence detector with a qualifying valid strobe,
// a saturating hit counter and exposed match progress (KMP-style automaton).
module seq_detector_param #(
  parameter int unsigned      LEN     = 3,
  parameter logic [LEN-1:0]   PATTERN = 3'b111,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8,
  localparam int unsigned     SW      = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in,
  input  logic             in_valid,
  output logic             out,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] count
);

  // One table entry per {state, in} pair; entries for unreachable states stay 0.
  localparam int unsigned NENT = 2 ** (SW + 1);

  // j-th bit on the line, j = 0 being the first bit (PATTERN[LEN-1]).
  function automatic logic pat_bit(int unsigned j);
    logic [LEN-1:0] sh;
    sh = PATTERN >> (LEN - 1 - j);
    return sh[0];
  endfunction

  // Longest prefix of PATTERN that is a suffix of (first s pattern bits, then b).
  function automatic int unsigned longest(int unsigned s, logic b);
    int unsigned best;
    int unsigned idx;
    logic        ok;
    logic        c;
    best = 0;
    for (int unsigned k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < k; i++) begin
        idx = s + 1 - k + i;
        c   = (idx == s) ? b : pat_bit(idx);
        if (c != pat_bit(i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic int unsigned border();
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned k = 1; k < LEN; k++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < k; i++) begin
        if (pat_bit(LEN - k + i) != pat_bit(i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic logic [NENT*SW-1:0] build_next();
    logic [NENT*SW-1:0] t;
    int unsigned        k;
    t = '0;
    for (int unsigned e = 0; e < NENT; e++) begin
      if ((e >> 1) < LEN) begin
        k = longest(e >> 1, ((e & 1) != 0));
        // A full match folds back to the border (overlap) or to the start.
        if (k == LEN) k = OVERLAP ? border() : 0;
        t[e*SW +: SW] = SW'(k);
      end
    end
    return t;
  endfunction

  localparam logic [NENT*SW-1:0] NEXT_TBL = build_next();

  logic [SW-1:0] nxt_tbl [NENT];

  for (genvar g = 0; g < NENT; g++) begin : g_tbl
    assign nxt_tbl[g] = NEXT_TBL[g*SW +: SW];
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_q, out_d;
  logic             hit;

  assign hit = in_valid && (state_q == SW'(LEN - 1)) && (in == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = 1'b0;
    if (in_valid) begin
      state_d = nxt_tbl[{state_q, in}];
      if (hit) begin
        out_d = 1'b1;
        if (count_q != '1) count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= '0;
      count_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign state = state_q;
  assign count = count_q;

endmodule
